// File: rtl/txshift.sv
// UART transmit shifter: sends an 11-bit frame LSB-first, one bit per baud-clock period.
// Optional build macro TXSHIFT_PARITY_EN replaces frame bit 9 with even parity of bits [8:1].
module txshift (
   input  logic        i_Pclk,
   input  logic        i_Reset,
   input  logic        i_Bclk,
   input  logic        i_Enable,
   input  logic        i_Start,
   input  logic [10:0] i_Data,
   output logic        o_Tx_Serial,
   output logic        o_Busy,
   output logic        o_Done
);

   typedef enum logic [1:0] {StIdle, StArmed, StShift} state_e;

   state_e      state_q, state_d;
   logic [10:0] frame_q, frame_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        bclk_q;
   logic        tx_q, tx_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        baud_edge;
   logic [10:0] load_frame;

   // bclk_q resets high so a high i_Bclk right after reset is not taken as an edge
   assign baud_edge = i_Bclk & ~bclk_q;

   always_comb begin
      load_frame = i_Data;
`ifdef TXSHIFT_PARITY_EN
      load_frame[9] = ^i_Data[8:1];
`else
      load_frame[9] = i_Data[9];
`endif
   end

   always_ff @(posedge i_Pclk) begin
      if (i_Reset) begin
         state_q <= StIdle;
         frame_q <= '1;
         cnt_q   <= '0;
         bclk_q  <= 1'b1;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         frame_q <= frame_d;
         cnt_q   <= cnt_d;
         bclk_q  <= i_Bclk;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      frame_d = frame_q;
      cnt_d   = cnt_q;
      tx_d    = tx_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      unique case (state_q)
         StIdle: begin
            tx_d = 1'b1;
            if (i_Start && i_Enable) begin
               frame_d = load_frame;
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = StArmed;
            end
         end
         StArmed, StShift: begin
            if (!i_Enable) begin
               tx_d    = 1'b1;
               busy_d  = 1'b0;
               cnt_d   = '0;
               state_d = StIdle;
            end else if (baud_edge) begin
               // cnt_q counts baud edges since arming; the 12th edge ends the stop bit
               if (cnt_q == 4'd11) begin
                  tx_d    = 1'b1;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  cnt_d   = '0;
                  state_d = StIdle;
               end else begin
                  tx_d    = frame_q[0];
                  frame_d = {1'b1, frame_q[10:1]};
                  cnt_d   = cnt_q + 4'd1;
                  state_d = StShift;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign o_Tx_Serial = tx_q;
   assign o_Busy      = busy_q;
   assign o_Done      = done_q;

endmodule

// File: tb/tb_txshift.sv
// Scoreboard bench for txshift: expected frames are queued when sent and checked bit by bit,
// including per-bit hold time, done pulse, back-to-back gap, abort and reset behaviour.
module tb_txshift;

   localparam int BitCycles = 174;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        bclk = 1'b0;
   logic        en = 1'b1;
   logic        start = 1'b0;
   logic [10:0] data = '0;
   logic        tx, busy, done;

   txshift dut (
      .i_Pclk     (clk),
      .i_Reset    (rst),
      .i_Bclk     (bclk),
      .i_Enable   (en),
      .i_Start    (start),
      .i_Data     (data),
      .o_Tx_Serial(tx),
      .o_Busy     (busy),
      .o_Done     (done)
   );

   typedef struct {
      logic [10:0] d;
      bit          gap;
   } exp_t;

   exp_t sb[$];
   int   n_total = 0;
   int   n_bad = 0;
   int   frames_chk = 0;
   int   done_cnt = 0;
   bit   mon_en = 1'b0;
   logic prev_tx = 1'b1;
   int   bcnt = 0;

   localparam logic [10:0] FrameA = 11'b10100011010;

   initial forever #5 clk = ~clk;

   // baud clock: 87 high, 87 low
   initial forever begin
      @(negedge clk);
      bcnt = (bcnt == BitCycles - 1) ? 0 : bcnt + 1;
      bclk = (bcnt < BitCycles / 2);
   end

   initial begin
      #(10 * 60000);
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   function automatic logic [10:0] model(input logic [10:0] d);
      logic [10:0] f;
      f = d;
`ifdef TXSHIFT_PARITY_EN
      f[9] = ^d[8:1];
`endif
      return f;
   endfunction

   task automatic check_eq(input string tag, input int obs, input int exp);
      n_total++;
      if (obs != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d want %0d", tag, obs, exp);
      end
   endtask

   // Entered on the first sample of a start bit; may chain into a back-to-back frame.
   task automatic run_frames();
      exp_t        e;
      logic [10:0] f;
      bit          more;
      int          m, n;
      more = 1'b1;
      while (more) begin
         more = 1'b0;
         check_eq("sb_nonempty", (sb.size() > 0) ? 1 : 0, 1);
         if (sb.size() == 0) return;
         e = sb.pop_front();
         f = model(e.d);
         for (int i = 0; i < 11; i++) begin
            m = 0;
            for (int k = 0; k < BitCycles; k++) begin
               if (tx === f[i]) m++;
               @(negedge clk);
            end
            check_eq($sformatf("bit%0d_hold", i), m, BitCycles);
         end
         check_eq("done_pulse", int'(done), 1);
         check_eq("stop_tx", int'(tx), 1);
         check_eq("busy_end", int'(busy), 0);
         frames_chk++;
         if (e.gap) begin
            n = 0;
            do begin
               @(negedge clk);
               n++;
            end while (tx !== 1'b0 && n < 1000);
            check_eq("b2b_gap", n, BitCycles);
            more = (tx === 1'b0);
         end
      end
   endtask

   initial forever begin
      @(negedge clk);
      if (mon_en && !rst && prev_tx === 1'b1 && tx === 1'b0) run_frames();
      prev_tx = tx;
   end

   initial forever begin
      @(negedge clk);
      if (done === 1'b1) done_cnt++;
   end

   task automatic send(input logic [10:0] d, input bit push);
      exp_t e;
      data  = d;
      start = 1'b1;
      if (push) begin
         e.d = d;
         e.gap = 1'b0;
         sb.push_back(e);
      end
      @(negedge clk);
      start = 1'b0;
      check_eq("busy_next", int'(busy), 1);
   endtask

   task automatic wait_frames(input int target);
      int n = 0;
      while (frames_chk < target && n < 6000) begin
         @(negedge clk);
         n++;
      end
      check_eq("frame_wait", frames_chk, target);
   endtask

   initial begin
      exp_t e;
      int   n;
      repeat (5) @(negedge clk);
      check_eq("rst_tx", int'(tx), 1);
      check_eq("rst_busy", int'(busy), 0);
      check_eq("rst_done", int'(done), 0);
      rst    = 1'b0;
      mon_en = 1'b1;
      repeat (3) @(negedge clk);
      check_eq("idle_tx", int'(tx), 1);

      send(FrameA, 1'b1);
      wait_frames(1);
      repeat (200) @(negedge clk);
      check_eq("idle_after", int'(tx), 1);

      send(11'b11000000110, 1'b1);
      wait_frames(2);
      send(11'b11000000010, 1'b1);
      wait_frames(3);

      // new request while busy must not disturb the latched frame
      send(11'b10110011100, 1'b1);
      repeat (300) @(negedge clk);
      data  = 11'b10001110010;
      start = 1'b1;
      repeat (20) @(negedge clk);
      start = 1'b0;
      data  = '0;
      wait_frames(4);
      repeat (5) @(negedge clk);
      check_eq("done_count4", done_cnt, 4);

      // enable drop during bit 5
      mon_en = 1'b0;
      send(FrameA, 1'b0);
      n = 0;
      while (tx !== 1'b0 && n < 400) begin
         @(negedge clk);
         n++;
      end
      check_eq("abort_start_seen", int'(tx), 0);
      repeat (5 * BitCycles + 20) @(negedge clk);
      check_eq("pre_abort_bit5", int'(tx), 0);
      en = 1'b0;
      @(negedge clk);
      check_eq("abort_tx", int'(tx), 1);
      check_eq("abort_busy", int'(busy), 0);
      repeat (400) @(negedge clk);
      check_eq("abort_no_done", done_cnt, 4);
      check_eq("abort_idle_tx", int'(tx), 1);
      en = 1'b1;
      repeat (5) @(negedge clk);

      // reset mid-frame with start held, then two back-to-back frames
      send(FrameA, 1'b0);
      repeat (600) @(negedge clk);
      rst   = 1'b1;
      start = 1'b1;
      data  = FrameA;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_eq("midrst_tx", int'(tx), 1);
         check_eq("midrst_busy", int'(busy), 0);
         check_eq("midrst_done", int'(done), 0);
      end
      e.d = FrameA;
      e.gap = 1'b1;
      sb.push_back(e);
      e.gap = 1'b0;
      sb.push_back(e);
      mon_en = 1'b1;
      rst    = 1'b0;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (done !== 1'b1 && n < 5000);
      check_eq("b2b_first_done", int'(done), 1);
      @(negedge clk);
      start = 1'b0;
      wait_frames(6);
      repeat (5) @(negedge clk);
      check_eq("done_count6", done_cnt, 6);
      check_eq("sb_drained", sb.size(), 0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/txshift.md
TXSHIFT -- requirements
Module: txshift

Interface
REQ-001 SHALL have port i_Pclk, input, 1 bit: system clock; all state changes on its rising edge.
REQ-002 SHALL have port i_Reset, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port i_Bclk, input, 1 bit: baud clock from baudgen; sampled in the i_Pclk domain, one bit period per i_Bclk period.
REQ-004 SHALL have port i_Enable, input, 1 bit: transmitter enable; low aborts or blocks transmission.
REQ-005 SHALL have port i_Start, input, 1 bit: request to send i_Data; level-sampled.
REQ-006 SHALL have port i_Data, input, 11 bits: frame, with [0] start, [8:1] payload, [9] parity, [10] stop.
REQ-007 SHALL have port o_Tx_Serial, output, 1 bit: serial line, idle high.
REQ-008 SHALL have port o_Busy, output, 1 bit: frame accepted and not yet finished.
REQ-009 SHALL have port o_Done, output, 1 bit: one-i_Pclk pulse at frame completion.

Function
REQ-010 SHALL detect a baud edge as i_Bclk==1 with the registered previous i_Bclk==0, at most one per i_Pclk cycle.
REQ-011 SHALL implement states IDLE, ARMED, SHIFT.
REQ-012 SHALL, in IDLE with i_Start=1 and i_Enable=1, latch i_Data into an 11-bit shift register, clear the 4-bit bit counter, enter ARMED, and assert o_Busy from the next cycle.
REQ-013 SHALL ignore i_Start while o_Busy=1; a new i_Data value SHALL NOT alter the latched frame.
REQ-014 SHALL, on the first baud edge in ARMED, drive o_Tx_Serial = frame[0] from the following cycle and enter SHIFT.
REQ-015 SHALL, on each baud edge in SHIFT, advance to the next bit LSB-first, so frame[n] is held for exactly one i_Bclk period for n = 0..10.
REQ-016 SHALL, on the 12th baud edge after arming, drive o_Tx_Serial=1, deassert o_Busy, pulse o_Done for one cycle, and return to IDLE.
REQ-017 SHALL ignore a baud edge that coincides with the i_Start acceptance cycle; the first bit goes out on the next edge.
REQ-018 SHALL accept i_Start in the o_Done cycle, giving back-to-back frames with a minimum one-bit idle (stop-high) gap.
REQ-019 SHALL, when i_Enable falls in ARMED or SHIFT, drive o_Tx_Serial=1 and o_Busy=0 from the next cycle, return to IDLE, and not assert o_Done.
REQ-020 SHALL keep the bit counter within 0..11 with no wrap-around.

Reset
REQ-021 SHALL, while i_Reset=1, set o_Tx_Serial=1, o_Busy=0, o_Done=0, state IDLE, counter 0, shift register all ones, and previous-i_Bclk register 1.
REQ-022 SHALL, on reset mid-frame, abandon the frame without an o_Done pulse, with reset taking priority over all other inputs.
REQ-023 SHALL NOT produce a baud edge in the first cycle after reset release, even if i_Bclk is high.

Configuration
REQ-024 SHALL, with TXSHIFT_PARITY_EN defined, transmit bit 9 as the computed even parity (XOR) of latched i_Data[8:1] and ignore i_Data[9].
REQ-025 SHALL, without TXSHIFT_PARITY_EN, transmit i_Data[9] unchanged; all other behaviour is identical in both builds.

Verification
REQ-026 SHALL cover: baud=87 (i_Bclk period 174 i_Pclk), i_Data=11'b10100011010, i_Start pulse -> o_Tx_Serial shows 0,1,0,1,1,0,0,0,1,0,1, each held 174 cycles; then o_Done pulses once and o_Tx_Serial=1.
REQ-027 SHALL cover: frame from REQ-026 looped into rxshift with the same baudgen -> rxshift o_Data=11'b10100011010 and its o_Done asserted.
REQ-028 SHALL cover: TXSHIFT_PARITY_EN defined, i_Data=11'b11000000110 (payload 0x03) -> bit 9 on the line = 0; with i_Data=11'b11000000010 (payload 0x01) -> bit 9 = 1.
REQ-029 SHALL cover: i_Enable dropped after 5th bit -> o_Tx_Serial=1 and o_Busy=0 next cycle, no o_Done pulse.
REQ-030 SHALL cover: i_Reset pulsed mid-frame, then i_Start held high continuously -> all outputs at reset values during reset; two back-to-back frames afterwards with exactly one high bit-time between stop and next start.
REQ-031 SHALL cover: i_Start asserted while o_Busy=1 with different i_Data -> the original frame is transmitted unchanged.
